// File: rtl/ahb_rr_burst_arbiter.sv
// ahb_rr_burst_arbiter: round-robin AHB mainbus arbiter that holds the grant across bursts and locked sequences
// Ports:
//   HCLK, HRESETn          bus clock, asynchronous active-low reset
//   req                    per-manager pending request
//   bus_htrans/hburst      transfer type and burst kind currently on the mainbus
//   bus_hmastlock          lock qualifier currently on the mainbus
//   hready                 mainbus HREADY; all state holds while low
//   grant, grant_id        one-hot and indexed address-phase owner
//   dp_owner, dp_valid     data-phase owner and whether that data phase is a real transfer
//   burst_active, locked   grant is pinned by a burst / by a locked sequence
module ahb_rr_burst_arbiter #(
  parameter int MANAGERS = 4,
  parameter int IDW      = $clog2(MANAGERS)
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [MANAGERS-1:0] req,
  input  logic [1:0]          bus_htrans,
  input  logic [2:0]          bus_hburst,
  input  logic                bus_hmastlock,
  input  logic                hready,
  output logic [MANAGERS-1:0] grant,
  output logic [IDW-1:0]      grant_id,
  output logic [IDW-1:0]      dp_owner,
  output logic                dp_valid,
  output logic                burst_active,
  output logic                locked
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  typedef enum logic [1:0] {S_PARK, S_BURST, S_INCR, S_LOCK} state_t;
  state_t              state_q, state_d, park_state;
  logic [3:0]          beats_q, beats_d, park_beats;
  logic                park_rearb, rearb, found;
  logic [MANAGERS-1:0] grant_q, grant_d;
  logic [IDW-1:0]      grant_id_q, grant_id_d, ptr_q, ptr_d, dp_owner_q, dp_owner_d, win;
  logic                dp_valid_q, dp_valid_d;
  logic [IDW:0]        scan, win_nxt;

  // Round-robin scan starting at ptr with wrap; the current owner competes too.
  always_comb begin
    win = '0;
    found = 1'b0;
    scan = '0;
    for (int i = 0; i < MANAGERS; i++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(i);
      scan = scan >= (IDW+1)'(MANAGERS) ? scan - (IDW+1)'(MANAGERS) : scan;
      if (!found && req[scan[IDW-1:0]]) begin
        win = scan[IDW-1:0];
        found = 1'b1;
      end
    end
    win_nxt = {1'b0, win} + (IDW+1)'(1);
  end

  // Decision for a transfer seen while not pinned: only a NONSEQ can pin the grant.
  always_comb begin
    park_state = S_PARK;
    park_beats = beats_q;
    park_rearb = 1'b1;
    if (bus_htrans == NONSEQ) begin
      park_rearb = bus_hmastlock ? 1'b0 : bus_hburst == SINGLE;
      park_state = bus_hmastlock ? S_LOCK :
                   bus_hburst == SINGLE ? S_PARK :
                   bus_hburst == INCR ? S_INCR : S_BURST;
      park_beats = bus_hburst[2:1] == 2'b01 ? 4'd3 :
                   bus_hburst[2:1] == 2'b10 ? 4'd7 : 4'd15;
    end
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    rearb = 1'b0;
    unique case (state_q)
      S_PARK: begin
        state_d = park_state;
        beats_d = park_beats;
        rearb = park_rearb;
      end
      S_BURST: begin
        if (bus_htrans == NONSEQ) begin
          state_d = park_state;
          beats_d = park_beats;
          rearb = park_rearb;
        end else if (bus_htrans == SEQ && beats_q > 4'd1) begin
          beats_d = beats_q - 4'd1;
        end else if (bus_htrans == SEQ || bus_htrans == IDLE) begin
          state_d = S_PARK;
          rearb = 1'b1;
        end
      end
      S_INCR: begin
        if (bus_htrans == NONSEQ) begin
          state_d = park_state;
          beats_d = park_beats;
          rearb = park_rearb;
        end else if (bus_htrans == IDLE) begin
          state_d = S_PARK;
          rearb = 1'b1;
        end
      end
      S_LOCK: begin
        if (!bus_hmastlock) begin
          state_d = park_state;
          beats_d = park_beats;
          rearb = park_rearb;
        end
      end
    endcase
    // With no requester the grant parks on its current owner.
    grant_d = rearb && found ? MANAGERS'(1) << win : grant_q;
    grant_id_d = rearb && found ? win : grant_id_q;
    ptr_d = !(rearb && found) ? ptr_q :
            win_nxt == (IDW+1)'(MANAGERS) ? '0 : win_nxt[IDW-1:0];
    dp_valid_d = bus_htrans[1];
    // The address phase accepted now becomes the data phase of today's owner.
    dp_owner_d = bus_htrans[1] ? grant_id_q : dp_owner_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_PARK;
      beats_q <= '0;
      grant_q <= MANAGERS'(1);
      grant_id_q <= '0;
      ptr_q <= '0;
      dp_owner_q <= '0;
      dp_valid_q <= 1'b0;
    end else if (hready) begin
      state_q <= state_d;
      beats_q <= beats_d;
      grant_q <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q <= ptr_d;
      dp_owner_q <= dp_owner_d;
      dp_valid_q <= dp_valid_d;
    end
  end

  assign grant = grant_q;
  assign grant_id = grant_id_q;
  assign dp_owner = dp_owner_q;
  assign dp_valid = dp_valid_q;
  assign burst_active = state_q == S_BURST || state_q == S_INCR;
  assign locked = state_q == S_LOCK;
endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// tb_ahb_rr_burst_arbiter: directed and randomized check of the arbiter against a transaction-level model
module tb_ahb_rr_burst_arbiter;
  localparam int N = 4;
  localparam int MD_PARK = 0;
  localparam int MD_FIXED = 1;
  localparam int MD_UNDEF = 2;
  localparam int MD_LOCK = 3;
  logic         HCLK = 1'b0;
  logic         HRESETn = 1'b0;
  logic [N-1:0] req = '0;
  logic [1:0]   bus_htrans = 2'b00;
  logic [2:0]   bus_hburst = 3'b000;
  logic         bus_hmastlock = 1'b0;
  logic         hready = 1'b1;
  logic [N-1:0] grant;
  logic [1:0]   grant_id, dp_owner;
  logic         dp_valid, burst_active, locked;
  int checks = 0;
  int errors = 0;
  int m_gid, m_ptr, m_mode, m_len, m_done, m_dpo;
  bit m_dpv;

  ahb_rr_burst_arbiter #(.MANAGERS(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .bus_htrans(bus_htrans),
    .bus_hburst(bus_hburst), .bus_hmastlock(bus_hmastlock), .hready(hready),
    .grant(grant), .grant_id(grant_id), .dp_owner(dp_owner), .dp_valid(dp_valid),
    .burst_active(burst_active), .locked(locked)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gid = 0;
    m_ptr = 0;
    m_mode = MD_PARK;
    m_len = 0;
    m_done = 0;
    m_dpo = 0;
    m_dpv = 0;
  endtask

  task automatic pick();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (req[c]) begin
        m_gid = c;
        m_ptr = (c + 1) % N;
        break;
      end
    end
  endtask

  // A fresh transfer decides whether the grant becomes pinned.
  task automatic start(output bit rb);
    int h;
    h = int'(bus_hburst);
    rb = 0;
    m_mode = MD_PARK;
    if (bus_htrans != 2'b10) rb = 1;
    else if (bus_hmastlock) m_mode = MD_LOCK;
    else if (h == 0) rb = 1;
    else if (h == 1) m_mode = MD_UNDEF;
    else begin
      m_mode = MD_FIXED;
      m_len = 4 << ((h - 2) / 2);
      m_done = 1;
    end
  endtask

  task automatic model_step();
    int t;
    bit rb, in_xfer;
    t = int'(bus_htrans);
    rb = 0;
    in_xfer = m_mode == MD_FIXED || m_mode == MD_UNDEF;
    if (t >= 2) m_dpo = m_gid;
    m_dpv = t >= 2;
    if (m_mode == MD_LOCK && bus_hmastlock) rb = 0;
    else if (in_xfer && t == 1) rb = 0;
    else if (m_mode == MD_UNDEF && t == 3) rb = 0;
    else if (m_mode == MD_FIXED && t == 3) begin
      m_done++;
      if (m_done == m_len) begin
        rb = 1;
        m_mode = MD_PARK;
      end
    end else if (in_xfer && t == 0) begin
      rb = 1;
      m_mode = MD_PARK;
    end else start(rb);
    if (rb) pick();
  endtask

  task automatic check_all();
    chk("grant", 32'(grant), 32'(1 << m_gid));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("dp_owner", 32'(dp_owner), 32'(m_dpo));
    chk("dp_valid", 32'(dp_valid), 32'(m_dpv));
    chk("burst_active", 32'(burst_active), 32'(m_mode == MD_FIXED || m_mode == MD_UNDEF));
    chk("locked", 32'(locked), 32'(m_mode == MD_LOCK));
  endtask

  // One clock: drive at a falling edge, step the model on an accepted edge, check at the next falling edge.
  task automatic cyc(input logic [3:0] r, input logic [1:0] t, input logic [2:0] b, input logic l, input logic h);
    req = r;
    bus_htrans = t;
    bus_hburst = b;
    bus_hmastlock = l;
    hready = h;
    @(posedge HCLK);
    if (h) model_step();
    @(negedge HCLK);
    check_all();
  endtask

  initial begin
    logic [3:0] g [3];
    logic [3:0] r;
    logic [1:0] t;
    logic [2:0] b;
    logic l, h;
    int x;
    model_reset();
    repeat (3) @(negedge HCLK);
    check_all();
    HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000, 2'b00, 3'b000, 1'b0, 1'b1);
      chk("park_grant", 32'(grant), 32'h1);
      chk("park_dpv", 32'(dp_valid), 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1010, 2'b10, 3'b000, 1'b0, 1'b1);
      g[i] = grant;
    end
    chk("rr0", 32'(g[0]), 32'h2);
    chk("rr1", 32'(g[1]), 32'h8);
    chk("rr2", 32'(g[2]), 32'h2);
    chk("rr_dpo", 32'(dp_owner), 32'h3);
    cyc(4'b0100, 2'b00, 3'b000, 1'b0, 1'b1);
    cyc(4'b1111, 2'b10, 3'b011, 1'b0, 1'b1);
    chk("incr4_nonseq", 32'(grant), 32'h4);
    cyc(4'b1111, 2'b11, 3'b011, 1'b0, 1'b1);
    cyc(4'b1111, 2'b01, 3'b011, 1'b0, 1'b1);
    cyc(4'b1111, 2'b11, 3'b011, 1'b0, 1'b1);
    chk("incr4_hold", 32'(grant), 32'h4);
    chk("incr4_active", 32'(burst_active), 32'h1);
    cyc(4'b1111, 2'b11, 3'b011, 1'b0, 1'b1);
    chk("incr4_handover", 32'(grant), 32'h8);
    chk("incr4_done", 32'(burst_active), 32'h0);
    for (int i = 0; i < 11; i++) begin
      cyc(4'b1111, i == 0 ? 2'b10 : 2'b11, 3'b101, 1'b0, !(i >= 3 && i <= 5));
      chk(i < 10 ? "incr8_hold" : "incr8_handover", 32'(grant), i < 10 ? 32'h8 : 32'h1);
    end
    cyc(4'b0010, 2'b00, 3'b000, 1'b0, 1'b1);
    cyc(4'b0010, 2'b10, 3'b001, 1'b0, 1'b1);
    cyc(4'b0010, 2'b11, 3'b001, 1'b0, 1'b1);
    cyc(4'b0010, 2'b01, 3'b001, 1'b0, 1'b1);
    chk("undef_active", 32'(burst_active), 32'h1);
    cyc(4'b0001, 2'b00, 3'b001, 1'b0, 1'b1);
    chk("undef_end_grant", 32'(grant), 32'h1);
    chk("undef_end_active", 32'(burst_active), 32'h0);
    cyc(4'b1000, 2'b00, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(4'b1111, 2'b10, 3'b000, 1'b1, 1'b1);
      chk("lock_grant", 32'(grant), 32'h8);
      chk("lock_flag", 32'(locked), 32'h1);
    end
    cyc(4'b1111, 2'b00, 3'b000, 1'b0, 1'b1);
    chk("unlock_grant", 32'(grant), 32'h1);
    chk("unlock_flag", 32'(locked), 32'h0);
    cyc(4'b0100, 2'b00, 3'b000, 1'b0, 1'b1);
    cyc(4'b1111, 2'b10, 3'b110, 1'b0, 1'b1);
    repeat (3) cyc(4'b1111, 2'b11, 3'b110, 1'b0, 1'b1);
    chk("wrap16_active", 32'(burst_active), 32'h1);
    #2;
    req = '0;
    bus_htrans = 2'b00;
    HRESETn = 1'b0;
    #1;
    chk("arst_grant", 32'(grant), 32'h1);
    chk("arst_gid", 32'(grant_id), 32'h0);
    chk("arst_dpo", 32'(dp_owner), 32'h0);
    chk("arst_dpv", 32'(dp_valid), 32'h0);
    chk("arst_active", 32'(burst_active), 32'h0);
    chk("arst_locked", 32'(locked), 32'h0);
    model_reset();
    @(negedge HCLK);
    check_all();
    HRESETn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = 4'($urandom_range(0, 15));
      h = $urandom_range(0, 3) != 0;
      l = m_mode == MD_LOCK ? $urandom_range(0, 5) != 0 : $urandom_range(0, 9) == 0;
      b = 3'($urandom_range(0, 7));
      x = $urandom_range(0, 9);
      if (m_mode == MD_FIXED || m_mode == MD_UNDEF)
        t = x < 6 ? 2'b11 : x < 7 ? 2'b01 : x < 8 ? 2'b00 : 2'b10;
      else if (m_mode == MD_LOCK && l)
        t = x < 4 ? 2'b10 : x < 7 ? 2'b11 : 2'b00;
      else
        t = x < 5 ? 2'b10 : x < 7 ? 2'b01 : 2'b00;
      cyc(r, t, b, l, h);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_rr_burst_arbiter.md
Name: ahb_rr_burst_arbiter

Overview:
- Arbitration controller for the multi-manager AHB interconnect. Decides which manager owns the mainbus address phase and tracks which manager owns the data phase.
- Round-robin fairness. Grant is held for the whole of a fixed-length burst, an undefined-length INCR burst, or a locked sequence.
- Its grant and data-phase-owner outputs steer the address mux and the response/HRDATA return mux inside the interconnect.

Parameters:
- MANAGERS, 4, number of requesting managers (2..16)
- IDW, $clog2(MANAGERS), width of manager index outputs

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  async active-low reset
- req  in  MANAGERS  per-manager pending request (live NONSEQ or stored NONSEQ)
- bus_htrans  in  2  HTRANS currently forwarded to mainbus by the granted manager
- bus_hburst  in  3  HBURST currently forwarded to mainbus
- bus_hmastlock  in  1  HMASTLOCK currently forwarded to mainbus
- hready  in  1  mainbus HREADY
- grant  out  MANAGERS  one-hot address-phase owner
- grant_id  out  IDW  index of grant
- dp_owner  out  IDW  index of the data-phase owner
- dp_valid  out  1  data phase in progress is a real (NONSEQ/SEQ) transfer
- burst_active  out  1  state is S_BURST or S_INCR
- locked  out  1  state is S_LOCK

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK. All state is updated on posedge HCLK.
- Reset values: grant=0001 (manager 0 parked), grant_id=0, rr pointer ptr=0, state=S_PARK, dp_owner=0, dp_valid=0, burst_active=0, locked=0.
- Hold rule: every register holds its value while hready=0. An "accepted edge" is a posedge with hready=1.
- Winner function (combinational):
  - Scan req from index ptr upward with modulo wrap; the first set bit wins.
  - The current owner's own req is included in the scan.
- Rearbitrate:
  - If req!=0: grant<=onehot(winner), grant_id<=winner, ptr<=(winner+1) mod MANAGERS.
  - If req==0: grant and ptr are unchanged (parking).
- Latency: req to grant is 1 accepted edge. The new owner drives the mainbus on the cycle after that edge.
- FSM decisions below are made on accepted edges, using bus_htrans, bus_hburst and bus_hmastlock sampled at that edge.
- S_PARK:
  - IDLE/BUSY: rearbitrate, stay.
  - NONSEQ with bus_hmastlock=1: go to S_LOCK, no rearbitration.
  - NONSEQ, SINGLE: rearbitrate, stay.
  - NONSEQ, INCR4/WRAP4: beats_left<=3, go to S_BURST, no rearbitration.
  - NONSEQ, INCR8/WRAP8: beats_left<=7, go to S_BURST, no rearbitration.
  - NONSEQ, INCR16/WRAP16: beats_left<=15, go to S_BURST, no rearbitration.
  - NONSEQ, INCR: go to S_INCR, no rearbitration.
- S_BURST:
  - SEQ with beats_left>1: decrement beats_left.
  - SEQ with beats_left==1: last beat accepted; rearbitrate, go to S_PARK.
  - BUSY: hold, no decrement.
  - IDLE (early termination): rearbitrate, go to S_PARK.
  - NONSEQ: handled exactly as in S_PARK (new transfer from the same owner).
- S_INCR:
  - SEQ/BUSY: hold.
  - IDLE: rearbitrate, go to S_PARK.
  - NONSEQ: handled as in S_PARK.
- S_LOCK:
  - Hold the grant while bus_hmastlock=1.
  - Accepted edge with bus_hmastlock=0: handled as in S_PARK.
- beats_left is 4 bits.
- Data-phase tracking, on every accepted edge:
  - dp_valid<=(bus_htrans is NONSEQ or SEQ).
  - dp_owner<=grant_id when dp_valid is set; otherwise dp_owner holds.
- Simultaneous events: a last-beat SEQ and a NONSEQ cannot coincide. When req changes on a non-accepted edge, it is ignored until the next accepted edge.
- Reset mid-burst: immediate return to reset values; the burst is abandoned.
- No grant is ever zero; exactly one grant bit is high at all times.

Test Plan:
- Reset, then req=0000 for 5 cycles -> grant=0001, grant_id=0, dp_valid=0 throughout.
- req=1010 held, hready=1, each owner issues SINGLE NONSEQ:
  - Grants alternate 0010 then 1000 then 0010, with ptr wrapping.
  - dp_owner follows grant_id one accepted edge later.
- Manager 2 granted issues INCR4, req=1111, one BUSY inserted:
  - Grant stays 0100 through NONSEQ, SEQ, BUSY, SEQ, SEQ.
  - Switches to 1000 on the edge after the 4th beat is accepted.
- INCR8 with hready=0 for 3 cycles mid-burst -> beats_left and grant frozen during the stall; handover is delayed by exactly 3 cycles.
- Manager 1 in S_INCR, then drives IDLE with req=0001 -> grant becomes 0001 on that accepted edge; burst_active drops.
- Manager 3 holds bus_hmastlock=1 across 6 SINGLE transfers with req=1111:
  - Grant is 1000 and locked=1 throughout.
  - First accepted edge with hmastlock=0 rearbitrates to 0001 (ptr=0 after winner 3).
- Assert HRESETn low mid-WRAP16 -> all outputs return to reset values asynchronously.
